hd_err_monitor: RTL and testbench
=================================

Name: hd_err_monitor

Overview:
- Sequential error-statistics stage that sits directly downstream of the Hamming-distance miter in the approximate-circuit evaluation flow.
- Consumes a stream of (exact, approximate) output-vector pairs and computes the per-sample Hamming distance (HD) in a pipelined stage.
- Accumulates error rate, violation count (HD > MHD), maximum HD, total HD and the first violating sample index over a run of N samples.
- Results are held stable for readout by the evaluation controller.

Parameters:
- BIT, 33, width of each compared vector
- MHD, 4, maximum tolerated Hamming distance; a sample violates when HD > MHD
- CNT_W, 32, width of sample counters and num_samples
- HD_W, 6, width of one HD value; must satisfy 2^HD_W > BIT

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a run (honoured in IDLE or DONE only)
- num_samples  in  CNT_W  samples in the run, sampled on the accepted start
- in_valid  in  1  a/b pair valid
- in_ready  out  1  block accepts a pair this cycle
- a  in  BIT  exact-circuit output vector
- b  in  BIT  approximate-circuit output vector
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- err_cnt  out  CNT_W  samples with HD > 0
- viol_cnt  out  CNT_W  samples with HD > MHD
- max_hd  out  HD_W  largest HD seen in the run
- hd_total  out  CNT_W+HD_W  sum of all HDs in the run
- viol_flag  out  1  sticky: at least one violation in the run
- first_viol_idx  out  CNT_W  0-based index of the first violating sample; 0 when there is no violation

Behaviour:
- Reset: FSM in IDLE. in_ready, busy and done are 0. All statistics outputs and internal counters are 0. Reset mid-run aborts the run immediately, with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: clear all statistics and latch N = num_samples.
  - N == 0: go to DONE on the next cycle with zero statistics.
  - Otherwise: go to RUN.
- start is ignored in RUN and DRAIN.
- RUN:
  - in_ready = 1 while acc_cnt < N.
  - A transfer occurs when in_valid && in_ready.
  - On the transfer that makes acc_cnt == N, go to DRAIN on the next cycle. in_ready is 0 from that cycle on.
- Pipeline:
  - Stage 1 registers hd = popcount(a ^ b) (HD_W bits), the sample index and a valid bit.
  - Stage 2 updates the statistics from the stage-1 register.
  - Statistics reflect a sample 2 cycles after its transfer. Stalls (in_valid = 0) insert bubbles; bubbles never update statistics.
- Stage-2 update for a valid sample with HD h:
  - hd_total += h.
  - If h > 0: err_cnt++.
  - If h > max_hd: max_hd = h.
  - If h > MHD: viol_cnt++. If viol_flag was 0, set viol_flag = 1 and first_viol_idx = sample index.
- Saturation: err_cnt, viol_cnt and hd_total saturate at all-ones and never wrap. hd_total is sized so it cannot saturate when N < 2^CNT_W.
- DRAIN: stay until both pipeline stages are empty (2 cycles after the last transfer), then go to DONE.
- DONE:
  - done = 1 and busy = 0. Statistics are held until the next accepted start.
  - start in DONE clears the statistics in the same edge and enters RUN (or DONE again if N == 0); done drops on the next cycle.
- Equality at the threshold is not a violation: h == MHD counts in err_cnt only.
- a and b are ignored when no transfer occurs.

Test Plan:
- Reset mid-run: rst after 3 accepted samples -> next cycle IDLE, all outputs 0, busy = 0, done = 0. A subsequent start with N = 2 behaves as a fresh run.
- Basic run: start with N = 4; pairs with HD {0, 4, 5, 33}, one per cycle with in_valid held high.
  - Required: in_ready is high for exactly 4 transfer cycles; done rises 2 cycles after the last transfer.
  - Final values: err_cnt = 3, viol_cnt = 2, max_hd = 33, hd_total = 42, viol_flag = 1, first_viol_idx = 2.
- Stalls: N = 3 with in_valid toggling 1,0,0,1,0,1 and HD {1, 6, 2} -> statistics unchanged during bubbles. Final values: err_cnt = 3, viol_cnt = 1, first_viol_idx = 1, max_hd = 6, hd_total = 9.
- Zero-length run: start with N = 0 -> in_ready never asserts; done = 1 one cycle after start; all statistics 0.
- Start handling: start pulsed in RUN is ignored and N is unchanged. start in DONE with N = 1 and HD {0} -> statistics cleared, done drops, then done returns. Final values: err_cnt = 0, viol_flag = 0, first_viol_idx = 0.
- Threshold boundary: N = 2, HD {4, 4} with MHD = 4 -> viol_cnt = 0, viol_flag = 0, err_cnt = 2, max_hd = 4.

Source files
------------

// File: rtl/hd_err_monitor.sv
// Purpose : error statistics over a run of N (exact, approximate) vector pairs from the HD miter.
// Latency : a sample's HD shows in the statistics 2 cycles after its transfer; done follows the last transfer by 2 cycles.
// Backpressure: in_ready is high only in RUN while fewer than N pairs are accepted; in_valid low inserts bubbles.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start, num_samples  begin a run of num_samples pairs (honoured in IDLE or DONE only)
//   in_valid/in_ready   pair handshake for vectors a (exact) and b (approximate)
//   busy, done          run in progress (RUN/DRAIN) / results held (DONE)
//   err_cnt, viol_cnt, max_hd, hd_total, viol_flag, first_viol_idx   run statistics
module hd_err_monitor #(
    parameter int BIT   = 33,
    parameter int MHD   = 4,
    parameter int CNT_W = 32,
    parameter int HD_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIT-1:0]          a,
    input  logic [BIT-1:0]          b,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        viol_cnt,
    output logic [HD_W-1:0]         max_hd,
    output logic [CNT_W+HD_W-1:0]   hd_total,
    output logic                    viol_flag,
    output logic [CNT_W-1:0]        first_viol_idx
);

    localparam int TOT_W = CNT_W + HD_W;
    localparam logic [HD_W-1:0] MHD_V = HD_W'(MHD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [HD_W-1:0] popcount(input logic [BIT-1:0] v);
        logic [HD_W-1:0] c;
        c = '0;
        for (int i = 0; i < BIT; i++) begin
            c = c + HD_W'(v[i]);
        end
        return c;
    endfunction

    // Control state
    state_t             state_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   acc_q;

    // Stage 1 register
    logic               s1_vld_q;
    logic [HD_W-1:0]    s1_hd_q;
    logic [CNT_W-1:0]   s1_idx_q;

    // Statistics (stage 2)
    logic [CNT_W-1:0]   err_q,   err_d;
    logic [CNT_W-1:0]   viol_q,  viol_d;
    logic [HD_W-1:0]    max_q,   max_d;
    logic [TOT_W-1:0]   tot_q,   tot_d;
    logic               flag_q,  flag_d;
    logic [CNT_W-1:0]   first_q, first_d;

    logic               xfer;
    logic               start_ok;
    logic [CNT_W-1:0]   acc_inc;
    logic [TOT_W:0]     tot_sum;

    assign xfer     = in_valid && in_ready_q;
    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign acc_inc  = acc_q + CNT_W'(1);
    // One extra bit catches the carry so the running total can saturate instead of wrapping.
    assign tot_sum  = {1'b0, tot_q} + (TOT_W+1)'(s1_hd_q);

    // ---------------------------------------------------------------
    // Run control FSM with registered handshake/status outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            n_q        <= '0;
            acc_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_q   <= num_samples;
                        acc_q <= '0;
                        if (num_samples == '0) begin
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            state_q    <= S_RUN;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        acc_q <= acc_inc;
                        if (acc_inc == n_q) begin
                            state_q    <= S_DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // On entry stage 1 holds the final sample and stage 2 retires it on
                    // this edge; nothing new can enter, so the pipeline is empty in DONE.
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: per-sample Hamming distance and index
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_hd_q  <= '0;
            s1_idx_q <= '0;
        end else begin
            s1_vld_q <= xfer;
            // Data registers only move on a transfer so idle a/b activity is ignored.
            if (xfer) begin
                s1_hd_q  <= popcount(a ^ b);
                s1_idx_q <= acc_q;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: statistics update
    // ---------------------------------------------------------------
    always_comb begin
        err_d   = err_q;
        viol_d  = viol_q;
        max_d   = max_q;
        tot_d   = tot_q;
        flag_d  = flag_q;
        first_d = first_q;
        if (start_ok) begin
            err_d   = '0;
            viol_d  = '0;
            max_d   = '0;
            tot_d   = '0;
            flag_d  = 1'b0;
            first_d = '0;
        end else if (s1_vld_q) begin
            tot_d = tot_sum[TOT_W] ? {TOT_W{1'b1}} : tot_sum[TOT_W-1:0];
            if ((s1_hd_q != '0) && (err_q != {CNT_W{1'b1}})) begin
                err_d = err_q + CNT_W'(1);
            end
            if (s1_hd_q > max_q) begin
                max_d = s1_hd_q;
            end
            // Strictly greater: an HD equal to the tolerance is an error, not a violation.
            if (s1_hd_q > MHD_V) begin
                if (viol_q != {CNT_W{1'b1}}) begin
                    viol_d = viol_q + CNT_W'(1);
                end
                if (!flag_q) begin
                    flag_d  = 1'b1;
                    first_d = s1_idx_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= '0;
            viol_q  <= '0;
            max_q   <= '0;
            tot_q   <= '0;
            flag_q  <= 1'b0;
            first_q <= '0;
        end else begin
            err_q   <= err_d;
            viol_q  <= viol_d;
            max_q   <= max_d;
            tot_q   <= tot_d;
            flag_q  <= flag_d;
            first_q <= first_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_q;
    assign viol_cnt       = viol_q;
    assign max_hd         = max_q;
    assign hd_total       = tot_q;
    assign viol_flag      = flag_q;
    assign first_viol_idx = first_q;

endmodule

// File: tb/tb_hd_err_monitor.sv
// Purpose : self-checking bench for hd_err_monitor; per-cycle statistics scoreboard plus per-scenario checks.
// Latency : expected statistics are queued at drive time and compared 2 cycles later.
// Backpressure: stimulus honours in_ready and inserts bubbles from a per-scenario valid pattern.
module tb_hd_err_monitor;

    localparam int BIT   = 33;
    localparam int MHD   = 4;
    localparam int CNT_W = 32;
    localparam int HD_W  = 6;
    localparam int TOT_W = CNT_W + HD_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNT_W-1:0]     num_samples;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT-1:0]       a;
    logic [BIT-1:0]       b;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W-1:0]     viol_cnt;
    logic [HD_W-1:0]      max_hd;
    logic [TOT_W-1:0]     hd_total;
    logic                 viol_flag;
    logic [CNT_W-1:0]     first_viol_idx;

    always #5 clk = ~clk;

    hd_err_monitor #(.BIT(BIT), .MHD(MHD), .CNT_W(CNT_W), .HD_W(HD_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .busy(busy), .done(done), .err_cnt(err_cnt), .viol_cnt(viol_cnt),
        .max_hd(max_hd), .hd_total(hd_total), .viol_flag(viol_flag),
        .first_viol_idx(first_viol_idx)
    );

    typedef struct packed {
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] viol;
        logic [HD_W-1:0]  mx;
        logic [TOT_W-1:0] tot;
        logic             flag;
        logic [CNT_W-1:0] first;
    } stats_t;

    typedef struct {
        int     due;
        stats_t st;
    } exp_t;

    exp_t   exp_q[$];
    stats_t model;
    int     m_idx;
    int     hd_q[$];
    bit     vp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    exp_t   mon_e;
    stats_t mon_act;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic stats_t dut_stats();
        stats_t s;
        s.err   = err_cnt;
        s.viol  = viol_cnt;
        s.mx    = max_hd;
        s.tot   = hd_total;
        s.flag  = viol_flag;
        s.first = first_viol_idx;
        return s;
    endfunction

    function automatic stats_t mk(input int e, input int v, input int m, input int t,
                                  input int f, input int fi);
        stats_t s;
        s.err   = CNT_W'(e);
        s.viol  = CNT_W'(v);
        s.mx    = HD_W'(m);
        s.tot   = TOT_W'(t);
        s.flag  = (f != 0);
        s.first = CNT_W'(fi);
        return s;
    endfunction

    task automatic model_clear();
        model = '0;
        m_idx = 0;
    endtask

    task automatic model_add(input int h);
        model.tot = model.tot + TOT_W'(h);
        if (h > 0) model.err = model.err + 1;
        if (HD_W'(h) > model.mx) model.mx = HD_W'(h);
        if (h > MHD) begin
            model.viol = model.viol + 1;
            if (!model.flag) begin
                model.flag  = 1'b1;
                model.first = CNT_W'(m_idx);
            end
        end
        m_idx++;
    endtask

    task automatic rand_ab();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        a = r[BIT-1:0];
        r = {$urandom(), $urandom()};
        b = r[BIT-1:0];
    endtask

    // Random exact vector; the approximate one differs in exactly h random-ish positions.
    task automatic set_pair(input int h);
        logic [63:0] r;
        logic [BIT-1:0] mask;
        int rot;
        r = {$urandom(), $urandom()};
        a = r[BIT-1:0];
        mask = '0;
        for (int i = 0; i < BIT; i++) mask[i] = (i < h);
        rot = $urandom_range(BIT-1, 0);
        for (int i = 0; i < rot; i++) mask = {mask[BIT-2:0], mask[BIT-1]};
        b = a ^ mask;
    endtask

    task automatic load_hd(input int n, input int h0, input int h1, input int h2, input int h3);
        hd_q.delete();
        if (n > 0) hd_q.push_back(h0);
        if (n > 1) hd_q.push_back(h1);
        if (n > 2) hd_q.push_back(h2);
        if (n > 3) hd_q.push_back(h3);
    endtask

    task automatic load_vp(input int n, input logic [7:0] pat);
        vp_q.delete();
        for (int i = 0; i < n; i++) vp_q.push_back(pat[i]);
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    // Drives hd_q following vp_q (all-valid once exhausted); queues expected stats every cycle.
    task automatic drive_samples(output int last_c, output int rdy_cyc);
        int k, p, guard;
        bit v;
        k = 0; p = 0; guard = 0; rdy_cyc = 0; last_c = cyc;
        while (k < hd_q.size() && guard < 200) begin
            v = (p < vp_q.size()) ? vp_q[p] : 1'b1;
            p++; guard++;
            in_valid = v;
            if (v) set_pair(hd_q[k]); else rand_ab();
            if (in_ready) rdy_cyc++;
            if (v && in_ready) begin
                model_add(hd_q[k]);
                last_c = cyc;
                k++;
            end
            exp_q.push_back('{cyc + 2, model});
            @(negedge clk);
        end
        in_valid = 1'b0;
        rand_ab();
        checks++;
        if (k != hd_q.size()) begin
            errors++;
            $display("FAIL drive_accept: accepted %0d pairs, required %0d", k, hd_q.size());
        end
    endtask

    task automatic wait_done(input int last_c, output int elapsed);
        int i;
        i = 0;
        while (!done && i < 50) begin
            @(negedge clk);
            i++;
        end
        elapsed = cyc - last_c;
    endtask

    // Scoreboard: compare queued expectations when their cycle comes up.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                mon_act = dut_stats();
                checks++;
                if (mon_act !== mon_e.st || mon_e.due != cyc) begin
                    errors++;
                    $display("FAIL stats_cycle@%0d: got %h required %h", cyc, mon_act, mon_e.st);
                end
            end
        end
    end

    task automatic test_reset();
        int lc, rc, el;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/done=%b required 000", {in_ready, busy, done});
        end
        checks++;
        if (dut_stats() !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_stats: got %h required 0", dut_stats());
        end
        rst = 1'b0;
        @(negedge clk);
        // Abort a run after three accepted samples.
        do_start(5);
        load_hd(3, 5, 6, 7, 0);
        load_vp(0, 8'h00);
        drive_samples(lc, rc);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, busy, done} !== 3'b000 || dut_stats() !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_midrun: ready/busy/done=%b stats=%h required 000 and 0",
                     {in_ready, busy, done}, dut_stats());
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_done: ready/busy/done=%b required 000", {in_ready, busy, done});
        end
        do_start(2);
        load_hd(2, 1, 7, 0, 0);
        drive_samples(lc, rc);
        wait_done(lc, el);
        checks++;
        if (done !== 1'b1 || el != 2) begin
            errors++;
            $display("FAIL reset_fresh_done: done=%b after %0d cycles, required 1 after 2", done, el);
        end
        checks++;
        if (dut_stats() !== mk(2, 1, 7, 8, 1, 1)) begin
            errors++;
            $display("FAIL reset_fresh_stats: got %h required %h", dut_stats(), mk(2, 1, 7, 8, 1, 1));
        end
    endtask

    task automatic test_basic();
        int lc, rc, el;
        do_start(4);
        load_hd(4, 0, 4, 5, 33);
        load_vp(0, 8'h00);
        drive_samples(lc, rc);
        checks++;
        if (rc != 4 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready: ready cycles %0d, in_ready after last %b, required 4 and 0", rc, in_ready);
        end
        wait_done(lc, el);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || el != 2) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b after %0d cycles, required 1/0 after 2", done, busy, el);
        end
        checks++;
        if (dut_stats() !== mk(3, 2, 33, 42, 1, 2)) begin
            errors++;
            $display("FAIL basic_stats: got %h required %h", dut_stats(), mk(3, 2, 33, 42, 1, 2));
        end
    endtask

    task automatic test_stalls();
        int lc, rc, el;
        do_start(3);
        load_hd(3, 1, 6, 2, 0);
        load_vp(6, 8'b0010_1001);
        drive_samples(lc, rc);
        wait_done(lc, el);
        checks++;
        if (done !== 1'b1 || el != 2) begin
            errors++;
            $display("FAIL stalls_done: done=%b after %0d cycles, required 1 after 2", done, el);
        end
        checks++;
        if (dut_stats() !== mk(3, 1, 6, 9, 1, 1)) begin
            errors++;
            $display("FAIL stalls_stats: got %h required %h", dut_stats(), mk(3, 1, 6, 9, 1, 1));
        end
    endtask

    task automatic test_zero_len();
        int hi;
        do_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_ctrl: done/busy/ready=%b required 100", {done, busy, in_ready});
        end
        checks++;
        if (dut_stats() !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_stats: got %h required 0", dut_stats());
        end
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready) hi++;
        end
        checks++;
        if (hi != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_hold: in_ready high %0d cycles done=%b, required 0 and 1", hi, done);
        end
    endtask

    task automatic test_start_handling();
        int lc, rc, el;
        do_start(3);
        load_hd(1, 0, 0, 0, 0);
        load_vp(0, 8'h00);
        drive_samples(lc, rc);
        // start in RUN with a different length must have no effect.
        start = 1'b1;
        num_samples = CNT_W'(1);
        in_valid = 1'b0;
        exp_q.push_back('{cyc + 2, model});
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, in_ready, done} !== 3'b110) begin
            errors++;
            $display("FAIL start_in_run: busy/ready/done=%b required 110", {busy, in_ready, done});
        end
        load_hd(2, 6, 0, 0, 0);
        drive_samples(lc, rc);
        wait_done(lc, el);
        checks++;
        if (done !== 1'b1 || el != 2 || dut_stats() !== mk(1, 1, 6, 6, 1, 1)) begin
            errors++;
            $display("FAIL start_ignored_stats: done=%b lat=%0d got %h required %h",
                     done, el, dut_stats(), mk(1, 1, 6, 6, 1, 1));
        end
        // Restart straight from DONE.
        do_start(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || dut_stats() !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL restart_clear: done=%b busy=%b stats=%h required 0/1/0", done, busy, dut_stats());
        end
        load_hd(1, 0, 0, 0, 0);
        drive_samples(lc, rc);
        wait_done(lc, el);
        checks++;
        if (done !== 1'b1 || el != 2 || dut_stats() !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL restart_final: done=%b lat=%0d got %h required done 1 lat 2 stats 0",
                     done, el, dut_stats());
        end
    endtask

    task automatic test_threshold();
        int lc, rc, el;
        do_start(2);
        load_hd(2, 4, 4, 0, 0);
        load_vp(0, 8'h00);
        drive_samples(lc, rc);
        wait_done(lc, el);
        checks++;
        if (done !== 1'b1 || dut_stats() !== mk(2, 0, 4, 8, 0, 0)) begin
            errors++;
            $display("FAIL threshold_stats: done=%b got %h required %h", done, dut_stats(), mk(2, 0, 4, 8, 0, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_stalls();
        test_zero_len();
        test_start_handling();
        test_threshold();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
